bus_arbiter: RTL

Round-robin bus arbiter for the shared system bus. Sits directly downstream of the bus masters: it samples each master's `h_req`/`h_lock`, issues a one-hot `h_grant`, and drives the owner index that steers the address/write-data mux toward the slaves. Ownership lasts until the owner releases at a completed transfer (`h_ready`), is extended by `h_lock`, and is bounded by a tenure limit when other masters wait.

---
 rtl/bus_arbiter_if.sv | 35 +++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbitration signal bundle shared by the masters and the round-robin arbiter.
// The parameter must match the MASTER_COUNT of the arbiter it is connected to.
interface bus_arbiter_if #(
    parameter int MASTER_COUNT = 4
);
    localparam int IW = $clog2(MASTER_COUNT);

    logic [MASTER_COUNT-1:0] h_req;
    logic [MASTER_COUNT-1:0] h_lock;
    logic                    h_ready;
    logic [MASTER_COUNT-1:0] h_grant;
    logic [IW-1:0]           h_owner;
    logic                    h_busy;
    logic                    h_locked;

    modport master (
        output h_req,
        output h_lock,
        output h_ready,
        input  h_grant,
        input  h_owner,
        input  h_busy,
        input  h_locked
    );

    modport slave (
        input  h_req,
        input  h_lock,
        input  h_ready,
        output h_grant,
        output h_owner,
        output h_busy,
        output h_locked
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one-hot registered grant, ownership held by lock/request/ready,
// bounded by a tenure limit while other masters are waiting.
module bus_arbiter #(
    parameter int MASTER_COUNT = 4,
    parameter int MAX_TENURE   = 16
) (
    input  logic            clk,
    input  logic            rst,
    bus_arbiter_if.slave    bus
);
    localparam int IW = $clog2(MASTER_COUNT);
    localparam int CW = $clog2(MAX_TENURE + 1);
    localparam logic [CW-1:0]           CNT_MAX  = CW'(MAX_TENURE);
    localparam logic [IW-1:0]           IDX_LAST = IW'(MASTER_COUNT - 1);
    localparam logic [MASTER_COUNT-1:0] ONE_HOT0 = {{(MASTER_COUNT-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t                  state_q,  state_d;
    logic [MASTER_COUNT-1:0] grant_q,  grant_d;
    logic [IW-1:0]           owner_q,  owner_d;
    logic                    busy_q,   busy_d;
    logic                    locked_q, locked_d;
    logic [CW-1:0]           cnt_q,    cnt_d;
    logic [IW-1:0]           ptr_q,    ptr_d;

    logic          win_vld_s;
    logic [IW-1:0] win_idx_s;
    logic          own_req_s;
    logic          own_lock_s;
    logic          other_req_s;
    logic          preempt_s;
    logic          release_s;

    // Search starts just after the last granted master and wraps at MASTER_COUNT,
    // so non-power-of-two counts never visit nonexistent indices.
    function automatic logic [IW:0] pick_winner(
        input logic [MASTER_COUNT-1:0] req,
        input logic [IW-1:0]           ptr
    );
        logic          found;
        logic [IW-1:0] idx;
        logic [IW-1:0] sel;
        found = 1'b0;
        idx   = ptr;
        sel   = {IW{1'b0}};
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (idx == IDX_LAST) begin
                idx = {IW{1'b0}};
            end else begin
                idx = idx + IW'(1);
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // Owner-qualified request/lock and the release decision.
    always_comb begin
        {win_vld_s, win_idx_s} = pick_winner(bus.h_req, ptr_q);
        own_req_s   = |(bus.h_req  & grant_q);
        own_lock_s  = |(bus.h_lock & grant_q);
        other_req_s = |(bus.h_req  & ~grant_q);
        preempt_s   = (cnt_q == CNT_MAX) && other_req_s && !own_lock_s;
        release_s   = bus.h_ready && !own_lock_s && (!own_req_s || preempt_s);
    end

    // Next-state and next-output computation for the IDLE/OWNED machine.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_d  = ST_OWNED;
                    grant_d  = ONE_HOT0 << win_idx_s;
                    owner_d  = win_idx_s;
                    busy_d   = 1'b1;
                    locked_d = 1'b0;
                    cnt_d    = {CW{1'b0}};
                    ptr_d    = win_idx_s;
                end else begin
                    grant_d  = {MASTER_COUNT{1'b0}};
                    busy_d   = 1'b0;
                    locked_d = 1'b0;
                end
            end
            ST_OWNED: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (release_s) begin
                    state_d  = ST_IDLE;
                    grant_d  = {MASTER_COUNT{1'b0}};
                    busy_d   = 1'b0;
                    locked_d = 1'b0;
                    cnt_d    = {CW{1'b0}};
                end else begin
                    locked_d = own_lock_s;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = {MASTER_COUNT{1'b0}};
                owner_d  = {IW{1'b0}};
                busy_d   = 1'b0;
                locked_d = 1'b0;
                cnt_d    = {CW{1'b0}};
                ptr_d    = IDX_LAST;
            end
        endcase
    end

    // State and registered outputs; reset leaves the pointer on the last master so master 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= {MASTER_COUNT{1'b0}};
            owner_q  <= {IW{1'b0}};
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            ptr_q    <= IDX_LAST;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.h_grant  = grant_q;
    assign bus.h_owner  = owner_q;
    assign bus.h_busy   = busy_q;
    assign bus.h_locked = locked_q;
endmodule
